posedge_detect: RTL and testbench
=================================

# posedge_detect

Rising-edge detector for a single debounced, clock-synchronous control input. It converts each 0→1 transition on `INC_db_in` into exactly one registered, one-clock-wide pulse on `POS_detect`. It sits between a push-button debouncer and the counter/control logic that must act once per press, not once per clock while the button is held.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`; 0 = reset.
- `INC_db_in`  input  1  debounced level input, already synchronous to `clk`; no internal synchronizer.
- `POS_detect`  output  1  registered one-cycle pulse; 1 for exactly one clock after a detected 0→1 transition.

## Operation
- Internal state:
  - `prev`: 1-bit history register holding the value of `INC_db_in` sampled at the previous rising edge.
  - `pulse`: 1-bit output register that drives `POS_detect`.
- On each rising edge of `clk` with `reset` = 1:
  - `prev` ← `INC_db_in`.
  - `pulse` ← `INC_db_in` AND NOT `prev`, using the old value of `prev`.
- On each rising edge of `clk` with `reset` = 0:
  - `prev` ← 0.
  - `pulse` ← 0.
  - `INC_db_in` is ignored.
- Held-high input: one pulse only. Pulse appears on the first edge that samples 1 after a sampled 0; all following edges that sample 1 give 0.
- Falling transitions (1→0) never produce a pulse.
- Post-reset rule: `prev` resets to 0. If `INC_db_in` is already 1 at the first edge with `reset` = 1, that counts as a rising edge and produces one pulse.
- No combinational path from `INC_db_in` to `POS_detect`.

## Timing
- Reset values: `POS_detect` = 0, `prev` = 0. Both take effect at the first rising edge that samples `reset` = 0.
- Latency: `INC_db_in` changes 0→1 between edge k−1 and edge k. `POS_detect` goes high just after edge k and returns low just after edge k+1, provided `reset` = 1 at both edges.
- Pulse width is exactly one clock period. Back-to-back pulses are impossible, because two rising edges need at least one sampled 0 between them.
- Minimum detectable pattern is 0,1 on two consecutive edges. An input 1→0→1 with each level held one cycle gives pulses 2 cycles apart.
- Glitches shorter than one clock that are not sampled at an edge are invisible. The debouncer upstream must guarantee setup/hold to `clk`.
- Reset mid-pulse: if `reset` = 0 at edge k+1 while the pulse is high, `POS_detect` clears at that edge, as it would anyway. `prev` clears too, so if the input is still 1 when reset releases, a new pulse fires one edge after release.
- Reset asserted on the same edge as a rising input: reset wins, no pulse.

## Test plan
- Reset: hold `reset` = 0 for 2 edges with `INC_db_in` toggling → `POS_detect` = 0 throughout.
- Single press: release reset with `INC_db_in` = 0, then raise `INC_db_in` before edge k and hold it high for 10 cycles → `POS_detect` = 1 only in the cycle after edge k; 0 for the other 9.
- Input high at release: `INC_db_in` = 1 while `reset` goes 0→1 → exactly one pulse after the first edge with `reset` = 1, then 0 while the input stays high.
- Repeated presses: input pattern 0,1,0,1,1,0,1 on consecutive edges → pulses after the edges sampling positions 2, 4 and 7 only; falling edges give no pulse.
- Reset collision: drive `reset` = 0 on the same edge that first samples `INC_db_in` = 1 → no pulse. Then release reset with the input still 1 → one pulse at the next edge.
- Steady levels: input held 0 for 20 cycles, then held 1 for 20 cycles → exactly one pulse total.

Source files
------------

// File: rtl/posedge_detect.sv
// Rising-edge detector for a debounced, clock-synchronous control input.
// Each 0->1 transition on INC_db_in yields exactly one registered, one-clock-wide
// pulse on POS_detect. Held-high input gives a single pulse; falling edges give none.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   reset      - synchronous active-low reset (0 = reset)
//   INC_db_in  - debounced level input, already synchronous to clk
//   POS_detect - registered one-cycle pulse after a detected rising edge
module posedge_detect (
  input  logic clk,
  input  logic reset,
  input  logic INC_db_in,
  output logic POS_detect
);

  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    prev_d  = INC_db_in;
    // Old prev_q is used here, so a level held high only pulses once.
    pulse_d = INC_db_in & ~prev_q;
  end

  // prev_q clears in reset so an input already high at release counts as a rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign POS_detect = pulse_q;

endmodule

// File: tb/tb_posedge_detect.sv
module tb_posedge_detect;

  logic clk;
  logic reset;
  logic INC_db_in;
  logic POS_detect;

  int checks;
  int errors;
  int pulses;

  posedge_detect dut (
    .clk       (clk),
    .reset     (reset),
    .INC_db_in (INC_db_in),
    .POS_detect(POS_detect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic step(input logic rst, input logic d);
    reset     = rst;
    INC_db_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic exp);
    checks++;
    assert (POS_detect === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, POS_detect, exp);
    end
  endtask

  logic [6:0] pat;
  logic [6:0] pat_exp;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    INC_db_in = 1'b0;

    // Reset held with input toggling
    step(1'b0, 1'b0); chk("reset_0", 1'b0);
    step(1'b0, 1'b1); chk("reset_1", 1'b0);
    step(1'b0, 1'b0); chk("reset_2", 1'b0);

    // Single press held for 10 cycles
    step(1'b1, 1'b0); chk("press_idle", 1'b0);
    step(1'b1, 1'b1); chk("press_pulse", 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1); chk("press_held", 1'b0);
    end

    // Input already high when reset releases
    step(1'b0, 1'b1); chk("rel_in_reset", 1'b0);
    step(1'b1, 1'b1); chk("rel_pulse", 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1); chk("rel_held", 1'b0);
    end

    // Repeated presses 0,1,0,1,1,0,1 -> pulses at positions 2, 4, 7
    step(1'b0, 1'b0); chk("rep_reset", 1'b0);
    pat     = 7'b0101101;
    pat_exp = 7'b0101001;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, pat[i]); chk("rep_seq", pat_exp[i]);
    end

    // Reset collides with the first sampled 1
    step(1'b1, 1'b0); chk("coll_idle", 1'b0);
    step(1'b0, 1'b1); chk("coll_reset_wins", 1'b0);
    step(1'b1, 1'b1); chk("coll_release_pulse", 1'b1);
    step(1'b1, 1'b1); chk("coll_held", 1'b0);

    // Reset mid-pulse, input still high at release
    step(1'b1, 1'b0); chk("mid_idle", 1'b0);
    step(1'b1, 1'b1); chk("mid_pulse", 1'b1);
    step(1'b0, 1'b1); chk("mid_reset_clear", 1'b0);
    step(1'b1, 1'b1); chk("mid_repulse", 1'b1);

    // Steady levels: 20 low then 20 high -> one pulse total
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0); chk("steady_low", 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      chk("steady_high", (i == 0) ? 1'b1 : 1'b0);
      if (POS_detect === 1'b1) pulses++;
    end
    checks++;
    assert (pulses == 1)
    else begin
      errors++;
      $error("FAIL steady_count: observed %0d expected 1", pulses);
    end

    // Falling edge then reset to finish
    step(1'b1, 1'b0); chk("fall_no_pulse", 1'b0);
    step(1'b0, 1'b0); chk("final_reset", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
